// File: rtl/qeciphy_rx_checker.sv
// Incrementing-count traffic checker for the QECIPHY RX AXI-Stream port, with hunt/lock alignment.
// Define QECIPHY_CHK_BITERR_EN to build the per-bit error counter; otherwise bit_err_cnt is tied to 0.
module qeciphy_rx_checker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 8
) (
    input  logic        ACLK,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic [63:0] rx_tdata,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    output logic        locked,
    output logic        err_sticky,
    output logic [47:0] word_cnt,
    output logic [31:0] err_cnt,
    output logic [31:0] bit_err_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HUNT   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [7:0] LOCK_RUN   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_RUN = 8'(UNLOCK_CNT);

    logic [1:0]  state_reg, state_next;
    logic [63:0] exp_reg, exp_next;
    logic [7:0]  run_reg, run_next;
    logic [7:0]  run_inc;
    logic        first_reg, first_next;
    logic        tready_reg;
    logic        sticky_reg, sticky_next;
    logic [47:0] word_cnt_reg, word_cnt_next;
    logic [31:0] err_cnt_reg, err_cnt_next;

    logic beat_match;
    logic locked_beat;
    logic err_beat;

    assign beat_match  = (rx_tdata == exp_reg);
    assign run_inc     = run_reg + 8'd1;
    assign locked_beat = en && rx_tvalid && (state_reg == ST_LOCKED);
    assign err_beat    = locked_beat && !beat_match;

    // first_reg marks the first beat after entering HUNT, which only seeds the prediction.
    always_comb begin
        state_next = state_reg;
        exp_next   = exp_reg;
        run_next   = run_reg;
        first_next = first_reg;
        if (!en) begin
            state_next = ST_IDLE;
            run_next   = 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_HUNT;
                    run_next   = 8'd0;
                    first_next = 1'b1;
                end
                ST_HUNT: begin
                    if (rx_tvalid) begin
                        exp_next   = rx_tdata + 64'd1;
                        first_next = 1'b0;
                        if (!first_reg && beat_match) begin
                            if (run_inc == LOCK_RUN) begin
                                state_next = ST_LOCKED;
                                run_next   = 8'd0;
                            end else begin
                                run_next = run_inc;
                            end
                        end else begin
                            run_next = 8'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (rx_tvalid) begin
                        // Free-running prediction: a single corrupted word costs exactly one error.
                        exp_next = exp_reg + 64'd1;
                        if (!beat_match) begin
                            if (run_inc == UNLOCK_RUN) begin
                                state_next = ST_HUNT;
                                run_next   = 8'd0;
                                first_next = 1'b1;
                            end else begin
                                run_next = run_inc;
                            end
                        end else begin
                            run_next = 8'd0;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    run_next   = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        word_cnt_next = word_cnt_reg;
        err_cnt_next  = err_cnt_reg;
        sticky_next   = sticky_reg;
        if (clr) begin
            word_cnt_next = 48'd0;
            err_cnt_next  = 32'd0;
            sticky_next   = 1'b0;
        end else begin
            if (locked_beat && !(&word_cnt_reg)) begin
                word_cnt_next = word_cnt_reg + 48'd1;
            end
            if (err_beat) begin
                sticky_next = 1'b1;
                if (!(&err_cnt_reg)) begin
                    err_cnt_next = err_cnt_reg + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            exp_reg      <= 64'd0;
            run_reg      <= 8'd0;
            first_reg    <= 1'b1;
            tready_reg   <= 1'b0;
            sticky_reg   <= 1'b0;
            word_cnt_reg <= 48'd0;
            err_cnt_reg  <= 32'd0;
        end else begin
            state_reg    <= state_next;
            exp_reg      <= exp_next;
            run_reg      <= run_next;
            first_reg    <= first_next;
            tready_reg   <= 1'b1;
            sticky_reg   <= sticky_next;
            word_cnt_reg <= word_cnt_next;
            err_cnt_reg  <= err_cnt_next;
        end
    end

`ifdef QECIPHY_CHK_BITERR_EN
    logic [63:0] diff_bits;
    logic [6:0]  popcnt;
    logic [32:0] bit_sum;
    logic [31:0] bit_err_cnt_reg, bit_err_cnt_next;

    assign diff_bits = rx_tdata ^ exp_reg;

    always_comb begin
        popcnt = 7'd0;
        for (int i = 0; i < 64; i++) begin
            popcnt = popcnt + 7'(diff_bits[i]);
        end
    end

    assign bit_sum = {1'b0, bit_err_cnt_reg} + {26'd0, popcnt};

    always_comb begin
        bit_err_cnt_next = bit_err_cnt_reg;
        if (clr) begin
            bit_err_cnt_next = 32'd0;
        end else if (err_beat) begin
            bit_err_cnt_next = bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
        end
    end

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            bit_err_cnt_reg <= 32'd0;
        end else begin
            bit_err_cnt_reg <= bit_err_cnt_next;
        end
    end

    assign bit_err_cnt = bit_err_cnt_reg;
`else
    assign bit_err_cnt = 32'd0;
`endif

    assign rx_tready  = tready_reg;
    assign locked     = (state_reg == ST_LOCKED);
    assign err_sticky = sticky_reg;
    assign word_cnt   = word_cnt_reg;
    assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_qeciphy_rx_checker.sv
// Directed-vector bench for qeciphy_rx_checker: a beat-level reference model checked every cycle,
// plus hand-computed milestones along the stimulus.
module tb_qeciphy_rx_checker;

    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 8;
    localparam longint unsigned WORD_MAX = 64'h0000_FFFF_FFFF_FFFF;
    localparam longint unsigned CNT32_MAX = 64'h0000_0000_FFFF_FFFF;
    localparam logic [31:0] PRESET_ERR = 32'hFFFF_FFFC;

    logic        ACLK;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic [63:0] rx_tdata;
    logic        rx_tvalid;
    logic        rx_tready;
    logic        locked;
    logic        err_sticky;
    logic [47:0] word_cnt;
    logic [31:0] err_cnt;
    logic [31:0] bit_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    qeciphy_rx_checker #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) dut (
        .ACLK        (ACLK),
        .rst_n       (rst_n),
        .en          (en),
        .clr         (clr),
        .rx_tdata    (rx_tdata),
        .rx_tvalid   (rx_tvalid),
        .rx_tready   (rx_tready),
        .locked      (locked),
        .err_sticky  (err_sticky),
        .word_cnt    (word_cnt),
        .err_cnt     (err_cnt),
        .bit_err_cnt (bit_err_cnt)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: one step per clock edge, expressed in beats and plain integers.
    typedef enum int {M_IDLE, M_HUNT, M_LOCKED} mstate_t;
    mstate_t         m_state;
    logic [63:0]     m_exp;
    int              m_run;
    bit              m_first;
    bit              m_tready;
    bit              m_sticky;
    longint unsigned m_word;
    longint unsigned m_err;
    longint unsigned m_bit;
    bit              seen_edge = 1'b0;
    int              preset_seq = 0;
    int              preset_seen = 0;

    always @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            m_state  = M_IDLE;
            m_exp    = 64'd0;
            m_run    = 0;
            m_first  = 1'b1;
            m_tready = 1'b0;
            m_sticky = 1'b0;
            m_word   = 0;
            m_err    = 0;
            m_bit    = 0;
        end else begin
            if (preset_seq != preset_seen) begin
                m_err = 64'(PRESET_ERR);
                preset_seen = preset_seq;
            end
            m_tready = 1'b1;
            if (!en) begin
                m_state = M_IDLE;
                m_run   = 0;
            end else if (m_state == M_IDLE) begin
                m_state = M_HUNT;
                m_run   = 0;
                m_first = 1'b1;
            end else if (rx_tvalid && m_state == M_HUNT) begin
                if (!m_first && rx_tdata == m_exp) m_run++;
                else m_run = 0;
                if (m_run == LOCK_CNT) begin
                    m_state = M_LOCKED;
                    m_run   = 0;
                end
                m_exp   = rx_tdata + 64'd1;
                m_first = 1'b0;
            end else if (rx_tvalid && m_state == M_LOCKED) begin
                if (m_word < WORD_MAX) m_word++;
                if (rx_tdata != m_exp) begin
                    if (m_err < CNT32_MAX) m_err++;
`ifdef QECIPHY_CHK_BITERR_EN
                    m_bit = m_bit + longint'($countones(rx_tdata ^ m_exp));
                    if (m_bit > CNT32_MAX) m_bit = CNT32_MAX;
`endif
                    m_sticky = 1'b1;
                    m_run++;
                    if (m_run == UNLOCK_CNT) begin
                        m_state = M_HUNT;
                        m_run   = 0;
                        m_first = 1'b1;
                    end
                end else begin
                    m_run = 0;
                end
                m_exp = m_exp + 64'd1;
            end
            if (clr) begin
                m_word   = 0;
                m_err    = 0;
                m_bit    = 0;
                m_sticky = 1'b0;
            end
        end
        seen_edge = 1'b1;
    end

    always @(negedge ACLK) begin
        if (seen_edge) begin
            chk("rx_tready", 64'(rx_tready), 64'(m_tready));
            chk("locked", 64'(locked), 64'(m_state == M_LOCKED));
            chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
            chk("word_cnt", 64'(word_cnt), m_word);
            chk("err_cnt", 64'(err_cnt), m_err);
            chk("bit_err_cnt", 64'(bit_err_cnt), m_bit);
        end
    end

    task automatic beat(input logic [63:0] d, input logic c = 1'b0);
        rx_tvalid = 1'b1;
        rx_tdata  = d;
        clr       = c;
        @(negedge ACLK);
        $display("beat en=%0b clr=%0b data=0x%016h -> locked=%0b words=%0d errs=%0d", en, c, d,
                 locked, word_cnt, err_cnt);
        clr = 1'b0;
    endtask

    task automatic gap(input logic c = 1'b0);
        rx_tvalid = 1'b0;
        clr       = c;
        @(negedge ACLK);
        $display("gap  en=%0b clr=%0b -> locked=%0b words=%0d errs=%0d", en, c, locked, word_cnt,
                 err_cnt);
        clr = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        clr       = 1'b0;
        rx_tvalid = 1'b0;
        rx_tdata  = 64'd0;
        repeat (3) @(negedge ACLK);
        chk("reset_tready", 64'(rx_tready), 64'd0);
        chk("reset_locked", 64'(locked), 64'd0);
        chk("reset_word", 64'(word_cnt), 64'd0);
        rst_n = 1'b1;
        gap();
        chk("tready_after_reset", 64'(rx_tready), 64'd1);

        // Acquire lock on 10..14
        en = 1'b1;
        gap();
        for (int i = 10; i <= 13; i++) beat(64'(i));
        chk("not_locked_after_13", 64'(locked), 64'd0);
        beat(64'd14);
        chk("locked_after_14", 64'(locked), 64'd1);
        chk("word_after_lock", 64'(word_cnt), 64'd0);
        chk("err_after_lock", 64'(err_cnt), 64'd0);

        // Single corrupted word: 0x20 replaced by 0x21
        for (int i = 15; i <= 31; i++) beat(64'(i));
        beat(64'h21);
        chk("single_err_cnt", 64'(err_cnt), 64'd1);
        chk("single_sticky", 64'(err_sticky), 64'd1);
        chk("single_locked", 64'(locked), 64'd1);
`ifdef QECIPHY_CHK_BITERR_EN
        chk("single_bit_err", 64'(bit_err_cnt), 64'd1);
`else
        chk("single_bit_err_off", 64'(bit_err_cnt), 64'd0);
`endif
        for (int i = 33; i <= 37; i++) beat(64'(i));
        chk("resync_err_cnt", 64'(err_cnt), 64'd1);
        chk("resync_word_cnt", 64'(word_cnt), 64'd23);

        // Clear on an idle cycle, then a +100 jump: 8 mismatches drop lock
        gap(1'b1);
        chk("clr_idle_word", 64'(word_cnt), 64'd0);
        for (int i = 0; i < 7; i++) beat(64'(38 + 100 + i));
        chk("jump_still_locked", 64'(locked), 64'd1);
        beat(64'(38 + 100 + 7));
        chk("jump_unlocked", 64'(locked), 64'd0);
        chk("jump_err_cnt", 64'(err_cnt), 64'd8);
        chk("jump_word_cnt", 64'(word_cnt), 64'd8);
        for (int i = 8; i < 12; i++) beat(64'(38 + 100 + i));
        chk("relock_pending", 64'(locked), 64'd0);
        beat(64'(38 + 100 + 12));
        chk("relocked", 64'(locked), 64'd1);
        chk("relock_word_frozen", 64'(word_cnt), 64'd8);

        // Drop en while locked, including beats while disabled
        en = 1'b0;
        gap();
        chk("en_off_locked", 64'(locked), 64'd0);
        for (int i = 0; i < 3; i++) beat(64'h5555 + 64'(i));
        gap();
        chk("en_off_word_frozen", 64'(word_cnt), 64'd8);
        chk("en_off_err_frozen", 64'(err_cnt), 64'd8);

        // Relock just below the 64-bit wrap and stream across it
        en = 1'b1;
        gap();
        for (int i = 0; i < 5; i++) beat(64'hFFFF_FFFF_FFFF_FFF9 + 64'(i));
        chk("wrap_locked", 64'(locked), 64'd1);
        for (int i = 0; i < 4; i++) beat(64'hFFFF_FFFF_FFFF_FFFE + 64'(i));
        chk("wrap_word_cnt", 64'(word_cnt), 64'd12);
        chk("wrap_err_cnt", 64'(err_cnt), 64'd8);

        // clr on the same edge as a locked beat
        beat(64'd2, 1'b1);
        chk("clr_beat_word", 64'(word_cnt), 64'd0);
        chk("clr_beat_err", 64'(err_cnt), 64'd0);
        chk("clr_beat_sticky", 64'(err_sticky), 64'd0);
        chk("clr_beat_locked", 64'(locked), 64'd1);
        beat(64'd3);
        chk("post_clr_word", 64'(word_cnt), 64'd1);

        // Preset err_cnt near full scale, then a burst of errors must saturate
        rx_tvalid = 1'b0;
        #1;
        force dut.err_cnt_reg = PRESET_ERR;
        preset_seq++;
        @(negedge ACLK);
        release dut.err_cnt_reg;
        for (int i = 0; i < 6; i++) beat(64'hDEAD_0000 + 64'(i));
        chk("sat_err_cnt", 64'(err_cnt), 64'h0000_0000_FFFF_FFFF);
        chk("sat_locked", 64'(locked), 64'd1);
        beat(64'd10);
        chk("sat_err_hold", 64'(err_cnt), 64'h0000_0000_FFFF_FFFF);
        chk("sat_word_cnt", 64'(word_cnt), 64'd8);
        gap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
